// File: rtl/lcd_write_arbiter.sv
// ============================================================================
// lcd_write_arbiter
//   Round-robin arbiter and write sequencer sharing one character-LCD driver
//   among four requesters, with line-change insertion and busy timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lcd_write_arbiter #(
  parameter int DATA_W      = 18,
  parameter int HOLD_CYCLES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [4*DATA_W-1:0]   req_data,
  input  logic [3:0]            req_line,
  output logic [3:0]            ack,
  output logic                  err,
  output logic                  drv_write,
  output logic [DATA_W-1:0]     drv_data,
  output logic                  drv_line,
  output logic                  drv_set_line,
  input  logic                  drv_busy,
  output logic [1:0]            cur_owner,
  output logic                  active
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETLINE   = 3'd1,
    S_STROBE    = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_ACK       = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          owner_q, owner_d;
  logic [1:0]          last_grant_q, last_grant_d;
  logic                last_line_q, last_line_d;
  logic                last_line_valid_q, last_line_valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                line_q, line_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [3:0]          ack_q, ack_d;
  logic                err_q, err_d;
  logic                drv_write_q, drv_write_d;
  logic                drv_set_line_q, drv_set_line_d;
  logic                active_q, active_d;

  logic [DATA_W-1:0]   req_word [4];
  logic                grant_found;
  logic [1:0]          grant_idx;
  logic [1:0]          cand;

  for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
    assign req_word[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Search starts one past the last served requester so every bit gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    cand        = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand = last_grant_q + 2'(i + 1);
      if (!grant_found && req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    last_grant_d      = last_grant_q;
    last_line_d       = last_line_q;
    last_line_valid_d = last_line_valid_q;
    data_d            = data_q;
    line_d            = line_q;
    hold_cnt_d        = hold_cnt_q;
    tmo_cnt_d         = tmo_cnt_q;
    err_d             = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          owner_d    = grant_idx;
          data_d     = req_word[grant_idx];
          line_d     = req_line[grant_idx];
          hold_cnt_d = '0;
          tmo_cnt_d  = '0;
          if (!last_line_valid_q || (req_line[grant_idx] != last_line_q))
            state_d = S_SETLINE;
          else
            state_d = S_STROBE;
        end
      end
      S_SETLINE: begin
        last_line_d       = line_q;
        last_line_valid_d = 1'b1;
        state_d           = S_STROBE;
      end
      S_STROBE: begin
        if (hold_cnt_q == HOLD_LAST)
          state_d = S_WAIT_BUSY;
        else
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
      S_WAIT_BUSY: begin
        // Busy seen in the last allowed cycle still wins over the timeout.
        if (drv_busy) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = S_ACK;
          err_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!drv_busy)
          state_d = S_ACK;
      end
      S_ACK: begin
        last_grant_d = owner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ack_d          = (state_d == S_ACK) ? (4'b0001 << owner_d) : 4'b0000;
    drv_write_d    = (state_d == S_STROBE);
    drv_set_line_d = (state_d == S_SETLINE);
    active_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      owner_q           <= 2'd0;
      last_grant_q      <= 2'd3;
      last_line_q       <= 1'b0;
      last_line_valid_q <= 1'b0;
      data_q            <= '0;
      line_q            <= 1'b0;
      hold_cnt_q        <= '0;
      tmo_cnt_q         <= '0;
      ack_q             <= 4'b0000;
      err_q             <= 1'b0;
      drv_write_q       <= 1'b0;
      drv_set_line_q    <= 1'b0;
      active_q          <= 1'b0;
    end else begin
      state_q           <= state_d;
      owner_q           <= owner_d;
      last_grant_q      <= last_grant_d;
      last_line_q       <= last_line_d;
      last_line_valid_q <= last_line_valid_d;
      data_q            <= data_d;
      line_q            <= line_d;
      hold_cnt_q        <= hold_cnt_d;
      tmo_cnt_q         <= tmo_cnt_d;
      ack_q             <= ack_d;
      err_q             <= err_d;
      drv_write_q       <= drv_write_d;
      drv_set_line_q    <= drv_set_line_d;
      active_q          <= active_d;
    end
  end

  assign ack          = ack_q;
  assign err          = err_q;
  assign drv_write    = drv_write_q;
  assign drv_data     = data_q;
  assign drv_line     = line_q;
  assign drv_set_line = drv_set_line_q;
  assign cur_owner    = owner_q;
  assign active       = active_q;

endmodule

`default_nettype wire

// File: doc/lcd_write_arbiter.md
# lcd_write_arbiter

Round-robin arbiter and write sequencer sharing one character-LCD driver among four requesters (status display, counter readout, refresh engine, debug). It accepts an 18-bit word plus line select from each requester, inserts a line-change command when the target line differs from the last one written, pulses the driver's write strobe, tracks the driver's busy handshake with a timeout, and acknowledges the owner. Sits between requester logic and `LCD_Driver` in the LCD top level, on the slow LCD clock domain.

## Interface

- `DATA_W`, 18, width of one driver word
- `HOLD_CYCLES`, 2, drv_write high time in clk cycles (>=1)
- `TIMEOUT`, 255, max cycles to wait for drv_busy rise before abandoning (>=1)

- `clk`  in  1  LCD-domain clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  4  request per requester; held high until its ack
- `req_data`  in  4*DATA_W  requester i word at [i*DATA_W +: DATA_W]; stable while req[i] high
- `req_line`  in  4  target LCD line per requester
- `ack`  out  4  one-cycle completion pulse to owner
- `err`  out  1  one-cycle pulse coincident with ack when transaction ended by timeout
- `drv_write`  out  1  write strobe to driver
- `drv_data`  out  DATA_W  latched word to driver
- `drv_line`  out  1  line select to driver
- `drv_set_line`  out  1  one-cycle line-change command
- `drv_busy`  in  1  driver processing flag
- `cur_owner`  out  2  index of granted requester
- `active`  out  1  high in every state except IDLE

## Operation

- States: IDLE, SETLINE, STROBE, WAIT_BUSY, WAIT_DONE, ACK. All outputs registered / Moore-decoded from state.
- IDLE: if any req bit set, grant first set bit searching from (last_grant+1) mod 4 upward with wrap; latch req_data, req_line, owner. Next SETLINE if latched line != last_line or last_line_valid=0, else STROBE. No req: stay.
- SETLINE: drv_set_line=1, drv_line=latched line, one cycle; last_line <= latched line, last_line_valid <= 1; next STROBE.
- STROBE: drv_write=1 for exactly HOLD_CYCLES cycles (hold counter), then WAIT_BUSY.
- WAIT_BUSY: drv_busy=1 -> WAIT_DONE. Otherwise timeout counter increments; at TIMEOUT cycles without busy -> ACK with err flagged.
- WAIT_DONE: wait for drv_busy=0 (no timeout) -> ACK.
- ACK: ack[owner]=1 (and err if flagged) for one cycle; last_grant <= owner; next IDLE.
- drv_data and drv_line hold latched values from grant until the next grant.
- Requesters deassert req at the clock edge on which they sample ack=1; a req still high in the following IDLE cycle is a new request.
- req dropped mid-transaction: ignored; transaction runs to ACK, ack still pulses.
- Requests arriving during a transaction wait; no queueing beyond req levels.
- rst in any state: state -> IDLE next edge, in-flight transaction abandoned without ack.

## Timing

- Reset values: ack=0, err=0, drv_write=0, drv_data=0, drv_line=0, drv_set_line=0, cur_owner=0, active=0, last_grant=3 (requester 0 highest priority first), last_line_valid=0, counters=0.
- Grant latency: req high in IDLE -> next cycle in SETLINE or STROBE.
- No line change, busy rises the cycle after strobe ends, busy held B cycles: ack asserted 1+HOLD_CYCLES+1+B+1 cycles after the IDLE grant edge... i.e. states IDLE(1), STROBE(HOLD_CYCLES), WAIT_BUSY(1), WAIT_DONE(B), ACK(1).
- Line change adds exactly one cycle (SETLINE).
- Timeout path: WAIT_BUSY occupies exactly TIMEOUT cycles, then ACK with err=1.
- drv_busy already high on entry to WAIT_BUSY counts as risen (WAIT_BUSY lasts one cycle).
- Back-to-back: minimum one IDLE cycle between ACK and next grant.

## Test plan

- Reset then single req[0], line 0, busy pulse 3 cycles after strobe: SETLINE on first transaction (last_line invalid), drv_data=req word, ack[0] single pulse, err=0.
- Second req[0] same line: no drv_set_line; req on line 1 next: drv_set_line pulse with drv_line=1 before STROBE.
- req=4'b1111 held continuously, busy responds each time: grant order 0,1,2,3,0; each ack one cycle; cur_owner matches.
- drv_busy never rises, TIMEOUT=255: WAIT_BUSY lasts 255 cycles, ack and err pulse together, arbiter returns to IDLE and serves next request.
- rst asserted during WAIT_DONE: next cycle state IDLE, all outputs at reset values, no ack; last_line_valid=0 forces SETLINE on next transaction.
- req[2] dropped during STROBE: transaction completes, ack[2] still pulses; drv_write high exactly HOLD_CYCLES=2 cycles.
